// File: rtl/serial_flag_gen_pkg.sv
// Shared definitions for the bit-serial add/subtract flag generator:
// FSM state encoding, operand width, default slice width and small helpers.
package serial_flag_gen_pkg;

    // Operand and result width
    localparam int unsigned OP_WIDTH = 32;

    // Default number of bits processed per BUSY cycle
    localparam int unsigned DEFAULT_STEP = 4;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of BUSY cycles needed to walk the whole operand
    function automatic int unsigned num_slices(input int unsigned step);
        return OP_WIDTH / step;
    endfunction

    // Width of a counter able to index every slice (at least one bit)
    function automatic int unsigned slice_cnt_width(input int unsigned step);
        int unsigned n;
        n = OP_WIDTH / step;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_flag_gen_slice_adder.sv
// Combinational STEP-bit adder slice with carry-in. Besides the sum and the
// carry out of the MSB it reports the carry into the MSB, which the parent
// needs for the signed overflow rule on the final slice.
module slice_adder
    import serial_flag_gen_pkg::*;
#(
    parameter int unsigned STEP = DEFAULT_STEP
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            cin,
    output logic [STEP-1:0] sum,
    output logic            cout,
    output logic            cmsb
);

    logic [STEP:0] total;

    // Ripple sum; carry into the MSB recovered from the MSB sum bit
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{STEP{1'b0}}, cin};
        sum   = total[STEP-1:0];
        cout  = total[STEP];
        cmsb  = a[STEP-1] ^ b[STEP-1] ^ total[STEP-1];
    end

endmodule

// File: rtl/serial_flag_gen.sv
// Bit-serial 32-bit adder/subtractor producing R and the Z/V/N flags.
// One STEP-bit slice is added per BUSY cycle, LSB first; results and flags
// are published together on entry to DONE and hold until the next completion.
module serial_flag_gen
    import serial_flag_gen_pkg::*;
#(
    parameter int unsigned STEP = DEFAULT_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] A,
    input  logic [OP_WIDTH-1:0] B,
    input  logic                Sub,
    input  logic                Sign,
    output logic                busy,
    output logic                done,
    output logic [OP_WIDTH-1:0] R,
    output logic                Z,
    output logic                V,
    output logic                N
);

    localparam int unsigned NSLICE = num_slices(STEP);
    localparam int unsigned CNT_W  = slice_cnt_width(STEP);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    state_t              state;
    logic [OP_WIDTH-1:0] a_sh;
    logic [OP_WIDTH-1:0] b_sh;
    logic [OP_WIDTH-1:0] acc_r;
    logic                sign_q;
    logic                carry_q;
    logic                zacc_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [STEP-1:0]     s_sum;
    logic                s_cout;
    logic                s_cmsb;
    logic [OP_WIDTH-1:0] acc_next;
    logic                zacc_next;
    logic                last_slice;

    slice_adder #(
        .STEP (STEP)
    ) u_slice (
        .a    (a_sh[STEP-1:0]),
        .b    (b_sh[STEP-1:0]),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .cmsb (s_cmsb)
    );

    // Next partial result (slice sum enters at the top) and zero accumulation
    always_comb begin
        acc_next   = (acc_r >> STEP) | (OP_WIDTH'(s_sum) << (OP_WIDTH - STEP));
        zacc_next  = zacc_q | (|s_sum);
        last_slice = (cnt_q == LAST_SLICE);
    end

    // Controller, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc_r   <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            R       <= '0;
            Z       <= 1'b0;
            V       <= 1'b0;
            N       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here, +1 via carry-in
                        a_sh    <= A;
                        b_sh    <= B ^ {OP_WIDTH{Sub}};
                        sign_q  <= Sign;
                        carry_q <= Sub;
                        cnt_q   <= '0;
                        zacc_q  <= 1'b0;
                        acc_r   <= '0;
                        busy    <= 1'b1;
                        state   <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    a_sh    <= a_sh >> STEP;
                    b_sh    <= b_sh >> STEP;
                    carry_q <= s_cout;
                    acc_r   <= acc_next;
                    zacc_q  <= zacc_next;
                    if (last_slice) begin
                        cnt_q <= '0;
                        R     <= acc_next;
                        Z     <= ~zacc_next;
                        V     <= sign_q ? (s_cmsb ^ s_cout) : s_cout;
                        N     <= acc_next[OP_WIDTH-1];
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_flag_gen.md
SERIAL_FLAG_GEN -- requirements
Module: serial_flag_gen

Interface
REQ-001 Parameter STEP, default 4: bits processed per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 A  input  32  first operand; sampled on the accept cycle.
REQ-006 B  input  32  second operand; sampled on the accept cycle.
REQ-007 Sub  input  1  1 = A-B (A + ~B + 1); 0 = A+B; sampled on accept.
REQ-008 Sign  input  1  1 = signed V rule, 0 = unsigned V rule; sampled on accept.
REQ-009 busy  output  1  high in BUSY and DONE.
REQ-010 done  output  1  one-cycle pulse; result and flags valid.
REQ-011 R  output  32  sum or difference.
REQ-012 Z  output  1  R == 0.
REQ-013 V  output  1  Sign=1: two's-complement overflow; Sign=0: carry-out of bit 31 (for Sub=1, 1 means no borrow).
REQ-014 N  output  1  R[31].

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY on start=1.
- BUSY->DONE after the last slice.
- DONE->IDLE unconditionally.
REQ-016 Accept cycle (IDLE, start=1) actions:
- latch A, B^{32{Sub}}, Sign.
- carry <= Sub.
- slice counter <= 0.
- zero-accumulator <= 0.
REQ-017 Each BUSY cycle adds one STEP-bit slice (LSB first) with carry-in, stores the carry, and shifts the slice sum into the top of the result register (shift right by STEP).
REQ-018 BUSY lasts exactly 32/STEP cycles; the last slice is the one with counter == 32/STEP-1; the counter wraps to 0 on that cycle.
REQ-019 The zero-accumulator ORs in every slice sum; Z = ~accumulator at completion.
REQ-020 On the last slice, capture the carry into bit 31 and the carry out of bit 31.
- V = Sign ? (cin31 ^ cout31) : cout31.
- N = result bit 31.
REQ-021 Flag and R update timing:
- R, Z, V, N update together on entry to DONE.
- done=1 only in DONE.
- R, Z, V, N hold until the next completion.
REQ-022 Latency: start accepted in cycle t gives done=1 in cycle t+32/STEP+1 (t+9 for STEP=4); the next start is accepted in cycle t+32/STEP+2 at the earliest.
REQ-023 start in BUSY or DONE is ignored with no side effects; A, B, Sub, Sign changes after accept have no effect.
REQ-024 Z, V, N, R are never driven from partially computed state; during BUSY they show the previous completed result.

Reset
REQ-025 reset=0 at a clock edge forces IDLE and clears every output and internal register: busy=0, done=0, R=0, Z=0, V=0, N=0, counter=0, carry=0.
REQ-026 Reset asserted mid-operation (BUSY or DONE) aborts it; no done pulse follows and outputs read 0.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 The shared ALU package holds:
- FSM state encoding (2 bits);
- operand width constant 32;
- default STEP constant.
REQ-029 One sub-module, slice_adder: a combinational STEP-bit adder with carry-in, sum, carry-out, and carry into its MSB; instantiated once.
REQ-030 Outputs Z, V, N use the same polarity and meaning the CMP flag inputs consume, so they connect directly to CMP.

Verification
REQ-031 Sign=1, Sub=1, A=0x80000000, B=0x00000001, start at t -> done at t+9: R=0x7FFFFFFF, Z=0, V=1, N=0.
REQ-032 Sign=0, Sub=1, A=3, B=5 -> R=0xFFFFFFFE, Z=0, V=0 (borrow), N=1; with Sign=1 the same operands give V=0, N=1.
REQ-033 Sign=0, Sub=0, A=0xFFFFFFFF, B=1 -> R=0, Z=1, V=1, N=0; with Sign=1, V=0.
REQ-034 Sign=1, Sub=1, A=B=5 -> R=0, Z=1, V=0, N=0. In the same run, hold start=1 continuously: accepts occur every 10 cycles and each done is exactly one cycle.
REQ-035 Start A=1, B=1, Sub=0, then pulse reset=0 in BUSY cycle 4 -> next cycle busy=0, R=0, Z=V=N=0, and no done. A fresh start then completes normally with R=2.
REQ-036 Change A, B, Sub and pulse start during BUSY -> result equals the originally accepted operands; exactly one done pulse.
